control_unit_fsm: RTL

//  Multi-cycle control unit for the register/ALU/RAM datapath: fetches the 32-bit LEGv8 instruction at PC,

---
 rtl/control_unit_fsm.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_unit_fsm.sv
// Multi-cycle LEGv8 control unit: fetch/decode/sequence, drives 29-bit control word and constant K.
// Latency: 2 cycles per instruction (ALU/imm/STUR/B/BR/B.cond), 3 for LDUR and CBZ/CBNZ.
// Backpressure: none; the FSM advances every clock, and HALT is left only through reset.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-high reset, returns to FETCH
//   instruction  32-bit instruction word at current PC (combinational ROM output)
//   status       datapath status register {V,C,N,Z}
//   controlWord  {PS[1:0],DA[4:0],SA[4:0],SB[4:0],FS[4:0],regW,ramW,selD[1:0],selB,PCsel,SL}
//   K            64-bit constant (B operand when selB=1, PC input when PCsel=1)
//   state        FSM state code: FETCH=0, EXEC=1, MEM=2, COND=3, HALT=4
//   halted       high while in HALT
module control_unit_fsm (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [3:0]  status,
    output logic [28:0] controlWord,
    output logic [63:0] K,
    output logic [2:0]  state,
    output logic        halted
);

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_OR  = 5'b00100;
    localparam logic [4:0] FS_XOR = 5'b01100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_LOAD = 2'b10;
    localparam logic [1:0] PS_REL  = 2'b11;

    localparam logic [1:0] SELD_RAM = 2'b00;
    localparam logic [1:0] SELD_ALU = 2'b01;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_BR   = 11'b11010110000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [7:0]  OP_BCND = 8'b01010100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_COND  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_ir;

    logic [1:0]  w_ps;
    logic [4:0]  w_da;
    logic [4:0]  w_sa;
    logic [4:0]  w_sb;
    logic [4:0]  w_fs;
    logic        w_regw;
    logic        w_ramw;
    logic [1:0]  w_seld;
    logic        w_selb;
    logic        w_pcsel;
    logic        w_sl;
    logic [63:0] w_k;

    logic [10:0] w_op11;
    logic [9:0]  w_op10;
    logic [7:0]  w_op8;
    logic [5:0]  w_op6;
    logic [4:0]  w_rd;
    logic [4:0]  w_rn;
    logic [4:0]  w_rm;
    logic [63:0] w_k_imm12;
    logic [63:0] w_k_dt;
    logic [63:0] w_k_br;
    logic [63:0] w_k_cb;
    logic        w_z;
    logic        w_n;
    logic        w_c;
    logic        w_v;
    logic        w_bcond_taken;
    logic        w_cb_taken;

    assign w_op11 = r_ir[31:21];
    assign w_op10 = r_ir[31:22];
    assign w_op8  = r_ir[31:24];
    assign w_op6  = r_ir[31:26];
    assign w_rd   = r_ir[4:0];
    assign w_rn   = r_ir[9:5];
    assign w_rm   = r_ir[20:16];

    assign w_k_imm12 = {52'd0, r_ir[21:10]};
    assign w_k_dt    = {{55{r_ir[20]}}, r_ir[20:12]};
    assign w_k_br    = {{38{r_ir[25]}}, r_ir[25:0]};
    assign w_k_cb    = {{45{r_ir[23]}}, r_ir[23:5]};

    assign w_z = status[0];
    assign w_n = status[1];
    assign w_c = status[2];
    assign w_v = status[3];

    always_comb begin
        w_bcond_taken = 1'b0;
        case (r_ir[3:0])
            4'b0000: w_bcond_taken = w_z;
            4'b0001: w_bcond_taken = ~w_z;
            4'b0010: w_bcond_taken = w_c;
            4'b0011: w_bcond_taken = ~w_c;
            4'b1010: w_bcond_taken = (w_n == w_v);
            4'b1011: w_bcond_taken = (w_n != w_v);
            4'b1100: w_bcond_taken = ~w_z & (w_n == w_v);
            4'b1101: w_bcond_taken = w_z | (w_n != w_v);
            4'b1110: w_bcond_taken = 1'b1;
            default: w_bcond_taken = 1'b0;
        endcase
    end

    // Bit 24 separates CBNZ from CBZ; Z reflects the OR of Rt with XZR done in EXEC.
    assign w_cb_taken = r_ir[24] ? ~w_z : w_z;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ir    <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_FETCH) begin
                r_ir <= instruction;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ps    = PS_HOLD;
        w_da    = 5'd0;
        w_sa    = 5'd0;
        w_sb    = 5'd0;
        w_fs    = FS_AND;
        w_regw  = 1'b0;
        w_ramw  = 1'b0;
        w_seld  = SELD_RAM;
        w_selb  = 1'b0;
        w_pcsel = 1'b0;
        w_sl    = 1'b0;
        w_k     = 64'd0;

        case (r_state)
            S_FETCH: w_next_state = S_EXEC;

            S_EXEC: begin
                // Longest opcode fields are tested first so a shorter pattern never shadows them.
                if (w_op11 == OP_ADD || w_op11 == OP_SUB || w_op11 == OP_AND ||
                    w_op11 == OP_ORR || w_op11 == OP_EOR) begin
                    w_da   = w_rd;
                    w_sa   = w_rn;
                    w_sb   = w_rm;
                    w_regw = 1'b1;
                    w_seld = SELD_ALU;
                    w_sl   = 1'b1;
                    w_ps   = PS_INC;
                    case (w_op11)
                        OP_ADD:  w_fs = FS_ADD;
                        OP_SUB:  w_fs = FS_SUB;
                        OP_AND:  w_fs = FS_AND;
                        OP_ORR:  w_fs = FS_OR;
                        default: w_fs = FS_XOR;
                    endcase
                    w_next_state = S_FETCH;
                end else if (w_op11 == OP_LDUR) begin
                    // Address phase only; the register write happens in MEM.
                    w_k    = w_k_dt;
                    w_sa   = w_rn;
                    w_da   = w_rd;
                    w_selb = 1'b1;
                    w_fs   = FS_ADD;
                    w_seld = SELD_RAM;
                    w_next_state = S_MEM;
                end else if (w_op11 == OP_STUR) begin
                    w_k    = w_k_dt;
                    w_sa   = w_rn;
                    w_sb   = w_rd;
                    w_selb = 1'b1;
                    w_fs   = FS_ADD;
                    w_ramw = 1'b1;
                    w_ps   = PS_INC;
                    w_next_state = S_FETCH;
                end else if (w_op11 == OP_BR) begin
                    w_sa = w_rn;
                    w_ps = PS_LOAD;
                    w_next_state = S_FETCH;
                end else if (w_op10 == OP_ADDI || w_op10 == OP_SUBI) begin
                    w_k    = w_k_imm12;
                    w_da   = w_rd;
                    w_sa   = w_rn;
                    w_selb = 1'b1;
                    w_fs   = (w_op10 == OP_ADDI) ? FS_ADD : FS_SUB;
                    w_regw = 1'b1;
                    w_seld = SELD_ALU;
                    w_sl   = 1'b1;
                    w_ps   = PS_INC;
                    w_next_state = S_FETCH;
                end else if (w_op8 == OP_CBZ || w_op8 == OP_CBNZ) begin
                    // Rt OR XZR sets Z in the status register, tested next cycle in COND.
                    w_sa = w_rd;
                    w_sb = 5'd31;
                    w_fs = FS_OR;
                    w_sl = 1'b1;
                    w_next_state = S_COND;
                end else if (w_op8 == OP_BCND) begin
                    w_k = w_k_cb;
                    if (w_bcond_taken) begin
                        w_pcsel = 1'b1;
                        w_ps    = PS_REL;
                    end else begin
                        w_ps = PS_INC;
                    end
                    w_next_state = S_FETCH;
                end else if (w_op6 == OP_B) begin
                    w_k     = w_k_br;
                    w_pcsel = 1'b1;
                    w_ps    = PS_REL;
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_HALT;
                end
            end

            S_MEM: begin
                w_k    = w_k_dt;
                w_sa   = w_rn;
                w_da   = w_rd;
                w_selb = 1'b1;
                w_fs   = FS_ADD;
                w_seld = SELD_RAM;
                w_regw = 1'b1;
                w_ps   = PS_INC;
                w_next_state = S_FETCH;
            end

            S_COND: begin
                w_k = w_k_cb;
                if (w_cb_taken) begin
                    w_pcsel = 1'b1;
                    w_ps    = PS_REL;
                end else begin
                    w_ps = PS_INC;
                end
                w_next_state = S_FETCH;
            end

            S_HALT: w_next_state = S_HALT;

            default: w_next_state = S_FETCH;
        endcase
    end

    // Writes aimed at XZR are suppressed here so every decode path gets it for free.
    assign controlWord = {w_ps, w_da, w_sa, w_sb, w_fs,
                          w_regw & (w_da != 5'd31), w_ramw, w_seld, w_selb, w_pcsel, w_sl};
    assign K      = w_k;
    assign state  = r_state;
    assign halted = (r_state == S_HALT);

endmodule
